// File: rtl/pc_unit.sv
// Program-counter unit: sequential, relative-branch, absolute-jump, call and
// return flow, with a circular return-address stack and sticky stack flags.
module pc_unit #(
  parameter int WIDTH         = 16,
  parameter int RESET_VECTOR  = 0,
  parameter int BRANCH_OFFSET = 2,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     op,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               pc_count,
  output logic [WIDTH-1:0]               pc_branch,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BREL = 3'd1,
    OP_JABS = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_t;

  // Circular pointer helpers; the stack index always stays below RAS_DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RAS_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (p == {PW{1'b0}}) begin
      return PW'(RAS_DEPTH - 1);
    end else begin
      return p - PW'(1);
    end
  endfunction

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]    top_r;
  logic [CW-1:0]    cnt_r;
  logic             ovf_r;
  logic             unf_r;

  op_t              op_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [PW-1:0]    next_top_s;
  logic [PW-1:0]    push_idx_s;
  logic [CW-1:0]    next_cnt_s;
  logic             push_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             ras_full_s;
  logic             ras_empty_s;

  assign op_s        = op_t'(op);
  assign pc_inc_s    = pc_r + WIDTH'(1);
  assign push_idx_s  = ptr_inc(top_r);
  assign ras_full_s  = (cnt_r == CW'(RAS_DEPTH));
  assign ras_empty_s = (cnt_r == {CW{1'b0}});

  // Next-state selection for the PC, stack pointer, depth and flag set requests.
  always_comb begin
    next_pc_s  = pc_inc_s;
    next_top_s = top_r;
    next_cnt_s = cnt_r;
    push_s     = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    case (op_s)
      OP_SEQ: begin
        next_pc_s = pc_inc_s;
      end
      OP_BREL: begin
        next_pc_s = pc_r + target;
      end
      OP_JABS: begin
        next_pc_s = target;
      end
      OP_CALL: begin
        push_s     = 1'b1;
        next_top_s = push_idx_s;
        next_pc_s  = target;
        // A full stack overwrites its oldest slot; depth stays saturated.
        if (ras_full_s) begin
          ovf_set_s  = 1'b1;
          next_cnt_s = cnt_r;
        end else begin
          next_cnt_s = cnt_r + CW'(1);
        end
      end
      OP_RET: begin
        if (ras_empty_s) begin
          unf_set_s = 1'b1;
          next_pc_s = pc_inc_s;
        end else begin
          next_pc_s  = ras_mem_r[top_r];
          next_top_s = ptr_dec(top_r);
          next_cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        next_pc_s = pc_inc_s;
      end
    endcase
  end

  // PC, stack pointer, depth and sticky flags; reset beats stall beats op.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r  <= WIDTH'(RESET_VECTOR);
      top_r <= PW'(RAS_DEPTH - 1);
      cnt_r <= {CW{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (stall) begin
      pc_r  <= pc_r;
      top_r <= top_r;
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
      unf_r <= unf_r;
    end else begin
      pc_r  <= next_pc_s;
      top_r <= next_top_s;
      cnt_r <= next_cnt_s;
      ovf_r <= ovf_r | ovf_set_s;
      unf_r <= unf_r | unf_set_s;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && !stall && push_s) begin
      ras_mem_r[push_idx_s] <= pc_inc_s;
    end
  end

  assign pc_count      = pc_r;
  assign pc_branch     = pc_r + WIDTH'(BRANCH_OFFSET);
  assign ras_count     = cnt_r;
  assign ras_overflow  = ovf_r;
  assign ras_underflow = unf_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps push hand-computed expectations,
// a monitor pops and compares them after every rising edge.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] target;
  logic [15:0] pc_count;
  logic [15:0] pc_branch;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [2:0] SEQ  = 3'd0;
  localparam logic [2:0] BREL = 3'd1;
  localparam logic [2:0] JABS = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;

  pc_unit #(
    .WIDTH(16), .RESET_VECTOR(0), .BRANCH_OFFSET(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target),
    .pc_count(pc_count), .pc_branch(pc_branch), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: every rising edge presents a new output state to score.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "pc",    pc_count,         e.pc);
        check(e.name, "br",    pc_branch,        e.pc + 16'd2);
        check(e.name, "cnt",   {13'd0, ras_count}, {13'd0, e.cnt});
        check(e.name, "ovf",   {15'd0, ras_overflow},  {15'd0, e.ovf});
        check(e.name, "unf",   {15'd0, ras_underflow}, {15'd0, e.unf});
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic stl,
                      input logic [2:0] o, input logic [15:0] t,
                      input logic [15:0] pc, input logic [2:0] cnt,
                      input logic ovf, input logic unf);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    stall  = stl;
    op     = o;
    target = t;
    e.name = name; e.pc = pc; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; op = SEQ; target = 16'h0000;
    //     name         rst   stl   op    target     pc        cnt   ovf   unf
    step("reset",      1'b1, 1'b0, SEQ,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("seq1",       1'b0, 1'b0, SEQ,  16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0);
    step("seq2",       1'b0, 1'b0, SEQ,  16'h0000, 16'h0002, 3'd0, 1'b0, 1'b0);
    step("seq3",       1'b0, 1'b0, SEQ,  16'h0000, 16'h0003, 3'd0, 1'b0, 1'b0);
    step("jabs10",     1'b0, 1'b0, JABS, 16'h0010, 16'h0010, 3'd0, 1'b0, 1'b0);
    step("brel_m4",    1'b0, 1'b0, BREL, 16'hFFFC, 16'h000C, 3'd0, 1'b0, 1'b0);
    step("brel_p8",    1'b0, 1'b0, BREL, 16'h0008, 16'h0014, 3'd0, 1'b0, 1'b0);
    step("jabs1234",   1'b0, 1'b0, JABS, 16'h1234, 16'h1234, 3'd0, 1'b0, 1'b0);
    step("op7_seq",    1'b0, 1'b0, 3'd7, 16'h5555, 16'h1235, 3'd0, 1'b0, 1'b0);
    // nested calls from 0x0005
    step("jabs5",      1'b0, 1'b0, JABS, 16'h0005, 16'h0005, 3'd0, 1'b0, 1'b0);
    step("call100",    1'b0, 1'b0, CALL, 16'h0100, 16'h0100, 3'd1, 1'b0, 1'b0);
    step("call200",    1'b0, 1'b0, CALL, 16'h0200, 16'h0200, 3'd2, 1'b0, 1'b0);
    step("ret_101",    1'b0, 1'b0, RET,  16'h0000, 16'h0101, 3'd1, 1'b0, 1'b0);
    step("ret_006",    1'b0, 1'b0, RET,  16'h0000, 16'h0006, 3'd0, 1'b0, 1'b0);
    // overflow: five calls into a four-deep stack
    step("ovf_c1",     1'b0, 1'b0, CALL, 16'h0010, 16'h0010, 3'd1, 1'b0, 1'b0);
    step("ovf_c2",     1'b0, 1'b0, CALL, 16'h0020, 16'h0020, 3'd2, 1'b0, 1'b0);
    step("ovf_c3",     1'b0, 1'b0, CALL, 16'h0030, 16'h0030, 3'd3, 1'b0, 1'b0);
    step("ovf_c4",     1'b0, 1'b0, CALL, 16'h0040, 16'h0040, 3'd4, 1'b0, 1'b0);
    step("ovf_c5",     1'b0, 1'b0, CALL, 16'h0050, 16'h0050, 3'd4, 1'b1, 1'b0);
    step("ovf_r1",     1'b0, 1'b0, RET,  16'h0000, 16'h0041, 3'd3, 1'b1, 1'b0);
    step("ovf_r2",     1'b0, 1'b0, RET,  16'h0000, 16'h0031, 3'd2, 1'b1, 1'b0);
    step("ovf_r3",     1'b0, 1'b0, RET,  16'h0000, 16'h0021, 3'd1, 1'b1, 1'b0);
    step("ovf_r4",     1'b0, 1'b0, RET,  16'h0000, 16'h0011, 3'd0, 1'b1, 1'b0);
    step("unf_r5",     1'b0, 1'b0, RET,  16'h0000, 16'h0012, 3'd0, 1'b1, 1'b1);
    // stall holds everything, then the JABS lands
    step("stall1",     1'b0, 1'b1, JABS, 16'h3333, 16'h0012, 3'd0, 1'b1, 1'b1);
    step("stall2",     1'b0, 1'b1, JABS, 16'h3333, 16'h0012, 3'd0, 1'b1, 1'b1);
    step("stall3",     1'b0, 1'b1, JABS, 16'h3333, 16'h0012, 3'd0, 1'b1, 1'b1);
    step("unstall",    1'b0, 1'b0, JABS, 16'h3333, 16'h3333, 3'd0, 1'b1, 1'b1);
    // reset on the same edge as a call clears flags and depth
    step("rst_call",   1'b1, 1'b0, CALL, 16'h0999, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("stall_ret",  1'b0, 1'b1, RET,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("jabsffff",   1'b0, 1'b0, JABS, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    step("seq_wrap",   1'b0, 1'b0, SEQ,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("jabsffff2",  1'b0, 1'b0, JABS, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    step("call_wrap",  1'b0, 1'b0, CALL, 16'h0040, 16'h0040, 3'd1, 1'b0, 1'b0);
    step("ret_wrap",   1'b0, 1'b0, RET,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("brel_wrap",  1'b0, 1'b0, BREL, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    // reset during a stall with a pending call
    step("call50",     1'b0, 1'b0, CALL, 16'h0050, 16'h0050, 3'd1, 1'b0, 1'b0);
    step("rst_stall",  1'b1, 1'b1, CALL, 16'h0777, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("post_seq",   1'b0, 1'b0, SEQ,  16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the 16RISC core, successor to the fixed 16-bit PC. It holds the fetch address and updates it each clock with sequential, relative-branch, absolute-jump, call or return flow. Calls and returns use an internal return-address stack (RAS). It sits between the decode/branch-resolve logic and instruction fetch. It keeps the `pc_branch = pc_count + BRANCH_OFFSET` side output used by BNE/BEQ.

## Interface
- `WIDTH`, default 16: PC width in bits.
- `RESET_VECTOR`, default 0: value loaded into the PC on reset.
- `BRANCH_OFFSET`, default 2: constant added to `pc_count` to form `pc_branch`.
- `RAS_DEPTH`, default 4: number of return-stack entries; must be ≥ 1.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `stall`, input, 1: when high, the PC and RAS hold their values.
- `op`, input, 3: flow select. 0 = SEQ, 1 = BREL, 2 = JABS, 3 = CALL, 4 = RET; values 5–7 behave as SEQ.
- `target`, input, WIDTH: signed offset for BREL; absolute address for JABS and CALL.
- `pc_count`, output, WIDTH: current PC, registered.
- `pc_branch`, output, WIDTH: `pc_count + BRANCH_OFFSET`, combinational, modulo 2^WIDTH.
- `ras_count`, output, $clog2(RAS_DEPTH+1): number of valid RAS entries, registered.
- `ras_overflow`, output, 1: sticky flag; set on a CALL made while the RAS is full.
- `ras_underflow`, output, 1: sticky flag; set on a RET made while the RAS is empty.

## Operation
- Priority order each edge: `reset` > `stall` > `op`.
- Reset:
  - `pc_count` = RESET_VECTOR.
  - `ras_count` = 0.
  - `ras_overflow` = 0 and `ras_underflow` = 0.
  - RAS contents are don't-care.
  - `pc_branch` follows combinationally (RESET_VECTOR + BRANCH_OFFSET).
- Stall: all registers hold and `op` is ignored.
- SEQ: `pc_count` ← `pc_count + 1`.
- BREL: `pc_count` ← `pc_count + target`, with `target` taken as two's complement.
- JABS: `pc_count` ← `target`.
- CALL:
  - Push `pc_count + 1` onto the RAS, then `pc_count` ← `target`.
  - If the RAS is full: the oldest entry is overwritten (circular buffer), `ras_count` stays at RAS_DEPTH, and `ras_overflow` ← 1.
- RET:
  - If `ras_count > 0`: pop the top entry into `pc_count` and decrement `ras_count`.
  - If the RAS is empty: `pc_count` ← `pc_count + 1` and `ras_underflow` ← 1.
- Arithmetic: all PC arithmetic wraps modulo 2^WIDTH, with no saturation and no carry output.
- Sticky flags clear only on reset.
- RAS organisation: circular array of RAS_DEPTH entries with a top pointer. Push writes at top+1; pop reads at top.

## Timing
- Every `pc_count` update takes effect one edge after `op`/`target` are sampled; latency is 1 cycle.
- `pc_branch` tracks `pc_count` in the same cycle, with zero latency.
- `ras_count` and the flags update on the same edge as `pc_count`.
- A CALL immediately followed by a RET returns to the call-site + 1 in the second cycle. The pushed value is visible to the next cycle's RET; no bypass is needed.
- `reset` asserted during a stall or mid call/return sequence: the next edge applies the reset values regardless of `op` or `stall`.
- `stall` asserted with RET on an empty RAS: no flag is set, because `op` is ignored during a stall.
- Wrap-around: SEQ from 2^WIDTH−1 gives 0. CALL from 2^WIDTH−1 pushes 0.

## Test plan
- Reset, then 3× SEQ (WIDTH=16, RESET_VECTOR=0): `pc_count` goes 0→1→2→3, and `pc_branch` = 5 after the third edge.
- At `pc_count`=0x0010, BREL with `target`=0xFFFC (−4) gives 0x000C. JABS with `target`=0x1234 then gives 0x1234.
- Nested calls, starting at PC 0x0005:
  - CALL to 0x0100, then CALL to 0x0200: `ras_count`=2.
  - RET gives 0x0101; a second RET gives 0x0006.
  - `ras_count`=0 and no flags are set.
- RAS_DEPTH=4:
  - 5 CALLs give `ras_overflow`=1 and `ras_count`=4.
  - 4 RETs return the 5th, 4th, 3rd and 2nd return addresses.
  - A 5th RET sets `ras_underflow`=1 and advances the PC by 1.
- `stall` held for 3 cycles with `op`=JABS: `pc_count` unchanged. The first edge after `stall` drops loads `target`.
- `pc_count`=0xFFFF with SEQ gives 0x0000. Asserting `reset` on the same edge as a CALL gives `pc_count`=RESET_VECTOR, `ras_count`=0, and both flags clear.
